// File: rtl/cu_vertex_cache_assoc_module.sv
// N-way set-associative vertex data cache for the PageRank PULL compute unit.
// Three-stage lookup pipeline (input register, synchronous RAM read,
// compare/result register) with round-robin replacement, fill forwarding,
// miss backpressure, a drain-then-sweep flush sequencer and hit/miss counters.
module cu_vertex_cache_assoc_module #(
  parameter int CACHE_ENTRIES_NUM = 64,
  parameter int CACHE_WAYS        = 2,
  parameter int VERTEX_ID_BITS    = 32,
  parameter int DATA_BITS         = 64,
  parameter int CMD_TAG_BITS      = 8
) (
  input  logic                      clock,
  input  logic                      rstn_in,
  input  logic                      enabled_in,
  input  logic                      flush_in,
  input  logic                      lookup_valid_in,
  output logic                      lookup_ready_out,
  input  logic [VERTEX_ID_BITS-1:0] lookup_id_in,
  input  logic [CMD_TAG_BITS-1:0]   lookup_tag_in,
  output logic                      hit_valid_out,
  output logic [VERTEX_ID_BITS-1:0] hit_id_out,
  output logic [CMD_TAG_BITS-1:0]   hit_tag_out,
  output logic [DATA_BITS-1:0]      hit_data_out,
  output logic                      miss_valid_out,
  input  logic                      miss_ready_in,
  output logic [VERTEX_ID_BITS-1:0] miss_id_out,
  output logic [CMD_TAG_BITS-1:0]   miss_tag_out,
  input  logic                      fill_valid_in,
  input  logic [VERTEX_ID_BITS-1:0] fill_id_in,
  input  logic [DATA_BITS-1:0]      fill_data_in,
  output logic                      flush_busy_out,
  output logic [31:0]               hit_count_out,
  output logic [31:0]               miss_count_out
);

  localparam int SETS       = CACHE_ENTRIES_NUM / CACHE_WAYS;
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = VERTEX_ID_BITS - INDEX_BITS;
  localparam int WAY_BITS   = (CACHE_WAYS > 1) ? $clog2(CACHE_WAYS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage: tags and data live in plain arrays, valid bits and replacement
  // pointers in resettable flops so reset and flush can clear them.
  // ---------------------------------------------------------------------------
  logic [TAG_BITS-1:0]   tag_mem  [SETS][CACHE_WAYS];
  logic [DATA_BITS-1:0]  data_mem [SETS][CACHE_WAYS];
  logic [CACHE_WAYS-1:0] valid_q  [SETS];
  logic [WAY_BITS-1:0]   rr_ptr_q [SETS];

  // Flush sequencer
  state_e                state_q;
  logic [INDEX_BITS-1:0] flush_idx_q;
  logic                  flush_busy_q;

  // Lookup pipeline
  logic                      s0_valid_q;
  logic [VERTEX_ID_BITS-1:0] s0_id_q;
  logic [CMD_TAG_BITS-1:0]   s0_cmd_tag_q;
  logic                      s1_valid_q;
  logic [VERTEX_ID_BITS-1:0] s1_id_q;
  logic [CMD_TAG_BITS-1:0]   s1_cmd_tag_q;
  logic [CACHE_WAYS-1:0]     rd_valid_q;
  logic [TAG_BITS-1:0]       rd_tag_q  [CACHE_WAYS];
  logic [DATA_BITS-1:0]      rd_data_q [CACHE_WAYS];

  // Result stage (drives the outputs directly)
  logic                      hit_valid_q;
  logic [VERTEX_ID_BITS-1:0] hit_id_q;
  logic [CMD_TAG_BITS-1:0]   hit_tag_q;
  logic [DATA_BITS-1:0]      hit_data_q;
  logic                      miss_valid_q;
  logic [VERTEX_ID_BITS-1:0] miss_id_q;
  logic [CMD_TAG_BITS-1:0]   miss_tag_q;
  logic [31:0]               hit_cnt_q;
  logic [31:0]               miss_cnt_q;

  // Fill input register
  logic                      fill_valid_q;
  logic [VERTEX_ID_BITS-1:0] fill_id_q;
  logic [DATA_BITS-1:0]      fill_data_q;

  // Combinational helpers
  logic                  stall;
  logic                  accept;
  logic                  pipe_empty;
  logic [INDEX_BITS-1:0] s0_index;
  logic [INDEX_BITS-1:0] s1_index;
  logic [TAG_BITS-1:0]   s1_tag;
  logic [INDEX_BITS-1:0] rd_index;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  wr_en;
  logic                  wr_present;
  logic [WAY_BITS-1:0]   wr_present_way;
  logic [WAY_BITS-1:0]   wr_way;
  logic [WAY_BITS-1:0]   rr_next;
  logic                  lk_hit;
  logic [DATA_BITS-1:0]  lk_data;

  // A held miss freezes the whole lookup pipeline.
  assign stall            = miss_valid_q & ~miss_ready_in;
  assign lookup_ready_out = enabled_in & (state_q == ST_IDLE) & ~stall;
  assign accept           = lookup_valid_in & lookup_ready_out;
  assign pipe_empty       = ~s0_valid_q & ~s1_valid_q & ~hit_valid_q & ~miss_valid_q;

  assign s0_index   = s0_id_q[INDEX_BITS-1:0];
  assign s1_index   = s1_id_q[INDEX_BITS-1:0];
  assign s1_tag     = s1_id_q[VERTEX_ID_BITS-1:INDEX_BITS];
  assign fill_index = fill_id_q[INDEX_BITS-1:0];
  assign fill_tag   = fill_id_q[VERTEX_ID_BITS-1:INDEX_BITS];
  assign wr_en      = fill_valid_q;

  // While stalled, keep reading the set of the lookup parked in S1.
  assign rd_index = stall ? s1_index : s0_index;

  // Flush sequencer: wait for in-flight lookups, then sweep one set per cycle.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q      <= ST_IDLE;
      flush_idx_q  <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_in) begin
            state_q      <= ST_DRAIN;
            flush_busy_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_idx_q == INDEX_BITS'(SETS - 1)) begin
            state_q      <= ST_IDLE;
            flush_busy_q <= 1'b0;
          end
          flush_idx_q <= flush_idx_q + INDEX_BITS'(1);
        end
        default: begin
          state_q      <= ST_IDLE;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Fill input register; fills arriving during the sweep are dropped.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      fill_valid_q <= 1'b0;
      fill_id_q    <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_valid_q <= fill_valid_in & (state_q != ST_FLUSH);
      if (fill_valid_in) begin
        fill_id_q   <= fill_id_in;
        fill_data_q <= fill_data_in;
      end
    end
  end

  // Pick the fill victim: an existing copy of the id first, else the RR way.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_present     = 1'b0;
    wr_present_way = '0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (!wr_present && valid_q[fill_index][w] && (tag_mem[fill_index][w] == fill_tag)) begin
        wr_present     = 1'b1;
        wr_present_way = WAY_BITS'(w);
      end
    end
    rr_next = (rr_ptr_q[fill_index] == WAY_BITS'(CACHE_WAYS - 1)) ?
              '0 : rr_ptr_q[fill_index] + WAY_BITS'(1);
    wr_way  = wr_present ? wr_present_way : rr_ptr_q[fill_index];
  end

  // Tag/data array writes from the registered fill.
  // NOTE: the tag and data arrays are deliberately not reset; the valid bits
  // alone decide whether their contents mean anything.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[fill_index][wr_way]  <= fill_tag;
      data_mem[fill_index][wr_way] <= fill_data_q;
    end
  end

  // Valid bits and RR pointers; the sweep clear is last so it beats a fill.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[fill_index][wr_way] <= 1'b1;
        if (!wr_present) begin
          rr_ptr_q[fill_index] <= rr_next;
        end
      end
      if (state_q == ST_FLUSH) begin
        valid_q[flush_idx_q]  <= '0;
        rr_ptr_q[flush_idx_q] <= '0;
      end
    end
  end

  // S0/S1 control and command fields; both hold while stalled.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      s0_valid_q   <= 1'b0;
      s0_id_q      <= '0;
      s0_cmd_tag_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_cmd_tag_q <= '0;
    end else if (!stall) begin
      s0_valid_q <= accept;
      if (accept) begin
        s0_id_q      <= lookup_id_in;
        s0_cmd_tag_q <= lookup_tag_in;
      end
      s1_valid_q   <= s0_valid_q;
      s1_id_q      <= s0_id_q;
      s1_cmd_tag_q <= s0_cmd_tag_q;
    end
  end

  // S1 valid-bit read, with the same-edge fill forwarded into the written way.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      rd_valid_q <= '0;
    end else begin
      for (int w = 0; w < CACHE_WAYS; w++) begin
        if (wr_en && (fill_index == rd_index) && (wr_way == WAY_BITS'(w))) begin
          rd_valid_q[w] <= 1'b1;
        end else begin
          rd_valid_q[w] <= valid_q[rd_index][w];
        end
      end
    end
  end

  // S1 synchronous tag/data read with the same fill forwarding.
  always_ff @(posedge clock) begin
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (wr_en && (fill_index == rd_index) && (wr_way == WAY_BITS'(w))) begin
        rd_tag_q[w]  <= fill_tag;
        rd_data_q[w] <= fill_data_q;
      end else begin
        rd_tag_q[w]  <= tag_mem[rd_index][w];
        rd_data_q[w] <= data_mem[rd_index][w];
      end
    end
  end

  // S2 tag compare; the lowest matching way wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (!lk_hit && rd_valid_q[w] && (rd_tag_q[w] == s1_tag)) begin
        lk_hit  = 1'b1;
        lk_data = rd_data_q[w];
      end
    end
  end

  // S2 result register and saturating statistics.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      hit_valid_q  <= 1'b0;
      hit_id_q     <= '0;
      hit_tag_q    <= '0;
      hit_data_q   <= '0;
      miss_valid_q <= 1'b0;
      miss_id_q    <= '0;
      miss_tag_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else if (stall) begin
      hit_valid_q <= 1'b0;
    end else begin
      hit_valid_q  <= s1_valid_q & lk_hit;
      miss_valid_q <= s1_valid_q & ~lk_hit;
      if (s1_valid_q) begin
        if (lk_hit) begin
          hit_id_q   <= s1_id_q;
          hit_tag_q  <= s1_cmd_tag_q;
          hit_data_q <= lk_data;
          if (hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end
        end else begin
          miss_id_q  <= s1_id_q;
          miss_tag_q <= s1_cmd_tag_q;
          if (miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
      end
    end
  end

  assign hit_valid_out  = hit_valid_q;
  assign hit_id_out     = hit_id_q;
  assign hit_tag_out    = hit_tag_q;
  assign hit_data_out   = hit_data_q;
  assign miss_valid_out = miss_valid_q;
  assign miss_id_out    = miss_id_q;
  assign miss_tag_out   = miss_tag_q;
  assign flush_busy_out = flush_busy_q;
  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;

endmodule

// File: tb/tb_cu_vertex_cache_assoc_module.sv
// Self-checking bench for cu_vertex_cache_assoc_module. A behavioural model
// (per-set line arrays, round-robin pointers, expected-result queue) predicts
// hits, misses, payloads and counters; directed sequences cover backpressure,
// flush timing and reset during a flush.
module tb_cu_vertex_cache_assoc_module;

  localparam int SETS = 32;
  localparam int WAYS = 2;

  logic        clock = 1'b0;
  logic        rstn_in;
  logic        enabled_in;
  logic        flush_in;
  logic        lookup_valid_in;
  logic        lookup_ready_out;
  logic [31:0] lookup_id_in;
  logic [7:0]  lookup_tag_in;
  logic        hit_valid_out;
  logic [31:0] hit_id_out;
  logic [7:0]  hit_tag_out;
  logic [63:0] hit_data_out;
  logic        miss_valid_out;
  logic        miss_ready_in;
  logic [31:0] miss_id_out;
  logic [7:0]  miss_tag_out;
  logic        fill_valid_in;
  logic [31:0] fill_id_in;
  logic [63:0] fill_data_in;
  logic        flush_busy_out;
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;

  always #5 clock = ~clock;

  cu_vertex_cache_assoc_module #(
    .CACHE_ENTRIES_NUM(64),
    .CACHE_WAYS       (WAYS),
    .VERTEX_ID_BITS   (32),
    .DATA_BITS        (64),
    .CMD_TAG_BITS     (8)
  ) dut (
    .clock           (clock),
    .rstn_in         (rstn_in),
    .enabled_in      (enabled_in),
    .flush_in        (flush_in),
    .lookup_valid_in (lookup_valid_in),
    .lookup_ready_out(lookup_ready_out),
    .lookup_id_in    (lookup_id_in),
    .lookup_tag_in   (lookup_tag_in),
    .hit_valid_out   (hit_valid_out),
    .hit_id_out      (hit_id_out),
    .hit_tag_out     (hit_tag_out),
    .hit_data_out    (hit_data_out),
    .miss_valid_out  (miss_valid_out),
    .miss_ready_in   (miss_ready_in),
    .miss_id_out     (miss_id_out),
    .miss_tag_out    (miss_tag_out),
    .fill_valid_in   (fill_valid_in),
    .fill_id_in      (fill_id_in),
    .fill_data_in    (fill_data_in),
    .flush_busy_out  (flush_busy_out),
    .hit_count_out   (hit_count_out),
    .miss_count_out  (miss_count_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_id    [SETS][WAYS];
  logic [63:0] m_data  [SETS][WAYS];
  int          m_rr    [SETS];
  int unsigned m_hits;
  int unsigned m_misses;

  typedef struct {
    int          due;
    bit          hit;
    logic [31:0] id;
    logic [7:0]  tag;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void model_fill(input logic [31:0] id, input logic [63:0] data);
    int s;
    int way;
    s   = int'(id % 32'(SETS));
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && m_valid[s][w] && m_id[s][w] == id) way = w;
    if (way < 0) begin
      way     = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][way] = 1'b1;
    m_id[s][way]    = id;
    m_data[s][way]  = data;
  endfunction

  function automatic void model_lookup(input logic [31:0] id, output bit hit, output logic [63:0] data);
    int s;
    s    = int'(id % 32'(SETS));
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[s][w] && m_id[s][w] == id) begin
        hit  = 1'b1;
        data = m_data[s][w];
      end
  endfunction

  // ---------------- stimulus engine ----------------
  int          cyc = 0;
  bit          chk_out = 1'b1;
  bit          chk_ready = 1'b1;
  bit          nx_en = 1'b1, nx_flush = 1'b0, nx_lv = 1'b0, nx_fv = 1'b0, nx_mr = 1'b1;
  logic [31:0] nx_id = '0, nx_fid = '0;
  logic [7:0]  nx_tag = '0;
  logic [63:0] nx_fdata = '0;

  // One cycle: check outputs of the current cycle, then drive its inputs.
  task automatic tick();
    exp_t        e;
    bit          h;
    logic [63:0] d;
    @(negedge clock);
    cyc++;
    if (chk_out) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("hit_valid", hit_valid_out, e.hit);
        check("miss_valid", miss_valid_out, !e.hit);
        if (e.hit) begin
          m_hits++;
          check("hit_id", hit_id_out, e.id);
          check("hit_tag", hit_tag_out, e.tag);
          check("hit_data", hit_data_out, e.data);
        end else begin
          m_misses++;
          check("miss_id", miss_id_out, e.id);
          check("miss_tag", miss_tag_out, e.tag);
        end
      end else begin
        check("hit_quiet", hit_valid_out, 0);
        check("miss_quiet", miss_valid_out, 0);
      end
      check("hit_count", hit_count_out, m_hits);
      check("miss_count", miss_count_out, m_misses);
    end
    if (chk_ready) check("lookup_ready", lookup_ready_out, enabled_in);
    enabled_in      = nx_en;
    flush_in        = nx_flush;
    lookup_valid_in = nx_lv;
    lookup_id_in    = nx_id;
    lookup_tag_in   = nx_tag;
    fill_valid_in   = nx_fv;
    fill_id_in      = nx_fid;
    fill_data_in    = nx_fdata;
    miss_ready_in   = nx_mr;
    if (nx_fv) model_fill(nx_fid, nx_fdata);
    if (nx_flush) model_clear();
    if (nx_lv && nx_en && chk_out) begin
      model_lookup(nx_id, h, d);
      exp_q.push_back('{due: cyc + 3, hit: h, id: nx_id, tag: nx_tag, data: d});
    end
  endtask

  task automatic idle_ticks(input int n);
    nx_lv = 1'b0; nx_fv = 1'b0; nx_flush = 1'b0; nx_en = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_lookup(input logic [31:0] id, input logic [7:0] tag);
    nx_lv = 1'b1; nx_id = id; nx_tag = tag;
    tick();
    nx_lv = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] id, input logic [63:0] data);
    nx_fv = 1'b1; nx_fid = id; nx_fdata = data;
    tick();
    nx_fv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int unsigned base;

    rstn_in = 1'b0; enabled_in = 1'b0; flush_in = 1'b0; lookup_valid_in = 1'b0;
    lookup_id_in = '0; lookup_tag_in = '0; miss_ready_in = 1'b1;
    fill_valid_in = 1'b0; fill_id_in = '0; fill_data_in = '0;
    model_clear();
    m_hits = 0; m_misses = 0;
    repeat (3) @(negedge clock);
    check("rst_hit_valid", hit_valid_out, 0);
    check("rst_miss_valid", miss_valid_out, 0);
    check("rst_hit_data", hit_data_out, 0);
    check("rst_miss_id", miss_id_out, 0);
    check("rst_flush_busy", flush_busy_out, 0);
    check("rst_hit_count", hit_count_out, 0);
    check("rst_miss_count", miss_count_out, 0);
    rstn_in = 1'b1;
    enabled_in = 1'b1;

    // Cold miss
    do_lookup(32'd5, 8'h11);
    idle_ticks(4);
    check("cold_miss_count", miss_count_out, 1);
    check("cold_hit_count", hit_count_out, 0);

    // Fill then hit three cycles later
    do_fill(32'd5, 64'hDEAD_BEEF);
    idle_ticks(2);
    do_lookup(32'd5, 8'h22);
    idle_ticks(4);
    check("fill_hit_count", hit_count_out, 1);

    // Round-robin in set 3: 67 evicts 3
    do_fill(32'd3, 64'h3333);
    do_fill(32'd35, 64'h3535);
    do_fill(32'd67, 64'h6767);
    do_lookup(32'd3, 8'h03);
    do_lookup(32'd35, 8'h35);
    do_lookup(32'd67, 8'h67);
    idle_ticks(4);
    check("rr_hit_count", hit_count_out, 3);
    check("rr_miss_count", miss_count_out, 2);

    // Fill forwarded into a lookup reading the same set on the same edge
    nx_fv = 1'b1; nx_fid = 32'd9; nx_fdata = 64'h0BAD_F00D_1234_5678;
    do_lookup(32'd9, 8'h33);
    nx_fv = 1'b0;
    idle_ticks(4);
    check("fwd_hit_count", hit_count_out, 4);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      nx_en    = ($urandom_range(0, 9) != 0);
      nx_lv    = ($urandom_range(0, 9) < 7);
      nx_id    = $urandom_range(0, 127);
      nx_tag   = 8'($urandom);
      nx_fv    = ($urandom_range(0, 9) < 4);
      nx_fid   = $urandom_range(0, 127);
      nx_fdata = {$urandom, $urandom};
      tick();
    end
    idle_ticks(4);

    // Flush: fill everything, last fill coincides with flush_in
    for (int i = 0; i < 64; i++) begin
      nx_fv = 1'b1; nx_fid = 32'(i); nx_fdata = {32'(i), ~32'(i)};
      nx_flush = (i == 63);
      tick();
    end
    nx_fv = 1'b0; nx_flush = 1'b0;
    chk_ready = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 4) check("flush_ready_low", lookup_ready_out, 0);
      if (flush_busy_out) busy_cycles++;
      else break;
    end
    check("flush_busy_cycles", busy_cycles, 33);
    chk_ready = 1'b1;
    do_lookup(32'd10, 8'hA0);
    do_lookup(32'd63, 8'hA1);
    idle_ticks(4);

    // Miss backpressure: miss 1 held, then 2 and 3 in order
    base = m_misses;
    chk_out = 1'b0; chk_ready = 1'b0; nx_mr = 1'b0;
    for (int i = 1; i <= 3; i++) do_lookup(32'(i), 8'(8'h40 + i));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_miss_valid", miss_valid_out, 1);
      check("bp_miss_id", miss_id_out, 1);
      check("bp_hit_none", hit_valid_out, 0);
      check("bp_ready_low", lookup_ready_out, 0);
      check("bp_miss_count", miss_count_out, base + 1);
    end
    nx_mr = 1'b1;
    tick();
    check("bp_release_id", miss_id_out, 1);
    tick();
    check("bp_second_valid", miss_valid_out, 1);
    check("bp_second_id", miss_id_out, 2);
    check("bp_second_tag", miss_tag_out, 8'h42);
    tick();
    check("bp_third_valid", miss_valid_out, 1);
    check("bp_third_id", miss_id_out, 3);
    tick();
    check("bp_drained", miss_valid_out, 0);
    check("bp_no_hit", hit_valid_out, 0);
    check("bp_ready_back", lookup_ready_out, 1);
    check("bp_total_misses", miss_count_out, base + 3);
    m_misses = base + 3;
    chk_out = 1'b1; chk_ready = 1'b1;

    // Reset in the middle of the flush sweep
    do_fill(32'd7, 64'h7777_7777);
    idle_ticks(2);
    do_lookup(32'd7, 8'h77);
    idle_ticks(4);
    nx_flush = 1'b1;
    tick();
    nx_flush = 1'b0;
    chk_ready = 1'b0;
    repeat (6) tick();
    check("pre_reset_busy", flush_busy_out, 1);
    rstn_in = 1'b0;
    #1;
    check("mid_rst_busy", flush_busy_out, 0);
    check("mid_rst_hit_count", hit_count_out, 0);
    check("mid_rst_miss_count", miss_count_out, 0);
    check("mid_rst_ready", lookup_ready_out, 1);
    m_hits = 0; m_misses = 0;
    model_clear();
    exp_q.delete();
    @(negedge clock);
    rstn_in = 1'b1;
    chk_ready = 1'b1;
    do_lookup(32'd7, 8'h78);
    idle_ticks(4);
    check("post_reset_miss", miss_count_out, 1);
    check("post_reset_busy", flush_busy_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
